// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rggen_rtl_pkg
// Description : Shared types and helpers for the register-block host adapters:
//               access direction and byte-strobe to bit-mask expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package rggen_rtl_pkg;

    // Direction of a register access as broadcast to the register slices
    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_access_t;

    localparam int c_BYTE_WIDTH = 8;

    // One byte strobe expands to eight identical mask bits
    function automatic logic [c_BYTE_WIDTH-1:0] rggen_byte_mask(input logic strobe);
        return {c_BYTE_WIDTH{strobe}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_apb_host_adapter_if.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_host_adapter_if
// Description : APB slave port plus register-slice broadcast/collect bus of
//               the APB host adapter. Signal names carry the adapter's view
//               (i_ = into the adapter, o_ = out of the adapter).
// Revision    : 1.0 - initial release
// ============================================================================
interface rggen_apb_host_adapter_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int REGISTERS     = 1
);

    // APB side
    logic                            i_psel;
    logic                            i_penable;
    logic [ADDRESS_WIDTH-1:0]        i_paddr;
    logic                            i_pwrite;
    logic [DATA_WIDTH-1:0]           i_pwdata;
    logic [DATA_WIDTH/c_BYTE_WIDTH-1:0] i_pstrb;
    logic                            o_pready;
    logic [DATA_WIDTH-1:0]           o_prdata;
    logic                            o_pslverr;

    // Register-slice side
    logic                            o_request;
    logic [ADDRESS_WIDTH-1:0]        o_address;
    logic                            o_write;
    logic [DATA_WIDTH-1:0]           o_write_data;
    logic [DATA_WIDTH-1:0]           o_write_mask;
    logic [REGISTERS-1:0]            i_select;
    logic [REGISTERS-1:0]            i_ready;
    logic [REGISTERS*DATA_WIDTH-1:0] i_read_data;

    // Adapter view
    modport master (
        input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
        output o_pready, o_prdata, o_pslverr,
        output o_request, o_address, o_write, o_write_data, o_write_mask,
        input  i_select, i_ready, i_read_data
    );

    // Environment view (APB interconnect and register slices)
    modport slave (
        output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
        input  o_pready, o_prdata, o_pslverr,
        input  o_request, o_address, o_write, o_write_data, o_write_mask,
        output i_select, i_ready, i_read_data
    );

endinterface
`default_nettype wire

// File: rtl/rggen_response_mux.sv
`default_nettype none
// ============================================================================
// Module      : rggen_response_mux
// Description : Collects the per-slice responses of a register block: ORs the
//               read data of slices that are both selected and ready, and
//               classifies the number of selected slices as none/one/many.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_response_mux
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REGISTERS  = 1
) (
    input  logic [REGISTERS-1:0]            i_select,
    input  logic [REGISTERS-1:0]            i_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic                            o_hit_none,
    output logic                            o_hit_one,
    output logic                            o_hit_many,
    output logic                            o_ready
);

    logic                  w_seen;
    logic                  w_many;
    logic [DATA_WIDTH-1:0] w_data;

    // Walk the slices: a second select marks an overlap, and only slices that
    // are selected and ready contribute read data
    always_comb begin
        w_seen = 1'b0;
        w_many = 1'b0;
        w_data = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_select[k]) begin
                w_many = w_many | w_seen;
                w_seen = 1'b1;
            end
            if (i_select[k] && i_ready[k]) begin
                w_data = w_data | i_read_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_read_data = w_data;
    assign o_hit_none  = ~w_seen;
    assign o_hit_one   = w_seen & ~w_many;
    assign o_hit_many  = w_many;
    assign o_ready     = |(i_select & i_ready);

endmodule
`default_nettype wire

// File: rtl/rggen_apb_host_adapter.sv
`default_nettype none
// ============================================================================
// Module      : rggen_apb_host_adapter
// Description : APB4 slave that turns each transfer into one request to the
//               attached register slices and returns their response as
//               PRDATA/PREADY/PSLVERR. Decode miss, overlapping selects and
//               a ready timeout all produce an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_apb_host_adapter
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int REGISTERS     = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rggen_apb_host_adapter_if.master bus
);

    localparam int c_STRB_WIDTH = DATA_WIDTH / c_BYTE_WIDTH;
    // The counter only has to reach TIMEOUT-1
    localparam int c_CNT_WIDTH  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_WIDTH-1:0] c_TIMEOUT_LAST =
        c_CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ACCESS   = 2'd1;
    localparam logic [1:0] c_ST_RESPONSE = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_address;
    rggen_access_t            r_access;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_write_mask;
    logic [DATA_WIDTH-1:0]    r_prdata;
    logic                     r_pslverr;
    logic [c_CNT_WIDTH-1:0]   r_count;

    logic                     w_setup;
    logic [DATA_WIDTH-1:0]    w_strobe_mask;
    logic [DATA_WIDTH-1:0]    w_mux_data;
    logic                     w_hit_none;
    logic                     w_hit_one;
    logic                     w_hit_many;
    logic                     w_slice_ready;
    logic                     w_success;
    logic                     w_timeout;
    logic                     w_done;
    logic                     w_error;

    // A setup phase is only recognised from IDLE; an enable phase without a
    // preceding setup therefore never starts a transfer
    assign w_setup = bus.i_psel & ~bus.i_penable;

    generate
        for (genvar b = 0; b < c_STRB_WIDTH; b++) begin : g_mask
            assign w_strobe_mask[b*c_BYTE_WIDTH +: c_BYTE_WIDTH] =
                rggen_byte_mask(bus.i_pstrb[b]);
        end
    endgenerate

    rggen_response_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .REGISTERS  (REGISTERS)
    ) u_response_mux (
        .i_select    (bus.i_select),
        .i_ready     (bus.i_ready),
        .i_read_data (bus.i_read_data),
        .o_read_data (w_mux_data),
        .o_hit_none  (w_hit_none),
        .o_hit_one   (w_hit_one),
        .o_hit_many  (w_hit_many),
        .o_ready     (w_slice_ready)
    );

    // A unique ready slice wins over a timeout expiring in the same cycle
    assign w_success = w_hit_one & w_slice_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_count == c_TIMEOUT_LAST);
    assign w_error   = w_hit_none | w_hit_many | (~w_success & w_timeout);
    assign w_done    = w_success | w_error;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_setup) begin
                    w_next_state = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: begin
                if (w_done) begin
                    w_next_state = c_ST_RESPONSE;
                end
            end
            c_ST_RESPONSE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: request and pready come straight from the state register
    always_comb begin
        bus.o_request    = (r_state == c_ST_ACCESS);
        bus.o_pready     = (r_state == c_ST_RESPONSE);
        bus.o_prdata     = r_prdata;
        bus.o_pslverr    = r_pslverr;
        bus.o_address    = r_address;
        bus.o_write      = (r_access == RGGEN_WRITE);
        bus.o_write_data = r_write_data;
        bus.o_write_mask = r_write_mask;
    end

    // Latch the transfer attributes on the setup phase; reads carry no mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_address    <= '0;
            r_access     <= RGGEN_READ;
            r_write_data <= '0;
            r_write_mask <= '0;
        end else if ((r_state == c_ST_IDLE) && w_setup) begin
            r_address    <= bus.i_paddr;
            r_access     <= bus.i_pwrite ? RGGEN_WRITE : RGGEN_READ;
            r_write_data <= bus.i_pwdata;
            r_write_mask <= bus.i_pwrite ? w_strobe_mask : '0;
        end
    end

    // Capture the response when the access phase ends; errors and writes
    // return zero data, and the values hold until the next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else if ((r_state == c_ST_ACCESS) && w_done) begin
            r_prdata  <= (w_success && (r_access == RGGEN_READ)) ? w_mux_data : '0;
            r_pslverr <= w_error;
        end
    end

    // Count access-phase cycles spent waiting; cleared outside ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == c_ST_ACCESS) && !w_done && (TIMEOUT != 0)) begin
            r_count <= r_count + c_CNT_WIDTH'(1);
        end else if (r_state != c_ST_ACCESS) begin
            r_count <= '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/rggen_apb_host_adapter.md
Name: rggen_apb_host_adapter

Overview:
- Initiator side of the register-block access protocol.
- Converts APB (v4, with PSTRB/PSLVERR) slave transactions into a single request/address/direction/write-data/write-mask broadcast to REGISTERS register slices.
- Collects per-register select/ready/read_data, returns PRDATA/PREADY/PSLVERR.
- Sits between the system APB interconnect and the generated register instances, including indirect registers whose select depends on an index field.

Parameters:
- ADDRESS_WIDTH, 16, byte address width seen by registers (PADDR low bits)
- DATA_WIDTH, 32, bus and register data width; multiple of 8
- REGISTERS, 1, number of register slices attached (>=1)
- TIMEOUT, 255, max ACCESS cycles waiting for ready before error; 0 disables timeout

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_psel  input  1  APB select
- i_penable  input  1  APB enable
- i_paddr  input  ADDRESS_WIDTH  APB address
- i_pwrite  input  1  1=write
- i_pwdata  input  DATA_WIDTH  write data
- i_pstrb  input  DATA_WIDTH/8  byte strobes
- o_pready  output  1  transfer complete
- o_prdata  output  DATA_WIDTH  read data
- o_pslverr  output  1  error response
- o_request  output  1  request to all registers
- o_address  output  ADDRESS_WIDTH  latched access address
- o_write  output  1  latched direction
- o_write_data  output  DATA_WIDTH  latched write data
- o_write_mask  output  DATA_WIDTH  byte strobes expanded to bits
- i_select  input  REGISTERS  per-register address/index hit
- i_ready  input  REGISTERS  per-register access done
- i_read_data  input  REGISTERS*DATA_WIDTH  per-register read data, slice k at [k*DW +: DW]

Behaviour:
- Reset: state IDLE, o_request=0, o_pready=0, o_pslverr=0, o_prdata=0, o_address/o_write/o_write_data/o_write_mask=0, timeout counter=0. Reset mid-transfer aborts it; no response is issued.
- FSM IDLE -> ACCESS -> RESPONSE -> IDLE.
- IDLE: on i_psel&!i_penable (setup phase), latch paddr/pwrite/pwdata and expanded pstrb (write reads back as all-ones mask for reads: mask=0 on read), go ACCESS. i_psel&i_penable without a preceding setup is ignored.
- ACCESS: o_request=1. Each cycle evaluate:
  - hit_count = popcount(i_select).
  - hit_count==0 -> error, go RESPONSE. This is a decode error or an index mismatch.
  - hit_count>1 -> error (overlap), go RESPONSE.
  - hit_count==1 and ready of that slice=1 -> capture read data (OR of i_read_data slices gated by select&ready; 0 for writes), pslverr=0, go RESPONSE.
  - Otherwise increment counter. If TIMEOUT!=0 and counter==TIMEOUT-1 -> error, go RESPONSE.
- Error responses drive o_prdata=0.
- RESPONSE: o_request=0, o_pready=1 for exactly one cycle with o_prdata/o_pslverr valid, counter cleared, then IDLE. o_pready is registered, so minimum transfer is setup + 2 access-phase cycles (PREADY low on first enable cycle).
- The request is one per transfer; registers see it deasserted for at least one cycle between back-to-back transfers.
- o_prdata and o_pslverr hold their values until the next RESPONSE (stable, not checked by APB outside PREADY).
- i_psel dropped during ACCESS (protocol violation): the access completes normally and the response is discarded by the bus.

Decomposition:
- Package rggen_rtl_pkg: typedef rggen_access_t (READ/WRITE) and function for strobe-to-bit-mask expansion; FSM state enum local to module.
- Sub-module rggen_response_mux: select/ready-gated OR reduction of i_read_data with hit-count (0/1/many) outputs; reusable by other host adapters.

Test Plan:
- Write 0xDEADBEEF, pstrb=4'b0011 to addr 0x10 (slice 2 selects, ready next cycle) -> o_write_mask=0x0000FFFF, o_request high 2 cycles, PREADY 1 cycle, PSLVERR=0.
- Read addr 0x10, slice 2 returns 0x12345678 with ready immediate -> PRDATA=0x12345678 on PREADY, PSLVERR=0, latency setup+2.
- Read addr 0x40 no select -> PREADY after 1 ACCESS cycle, PSLVERR=1, PRDATA=0, no register state change.
- Two slices select addr 0x08 -> PSLVERR=1, PRDATA=0.
- TIMEOUT=4, selected slice never ready -> request high exactly 4 cycles, then PSLVERR=1; TIMEOUT=0 with ready after 300 cycles -> PSLVERR=0.
- Assert rst_n=0 during ACCESS -> o_request/o_pready drop asynchronously to 0; next transfer after release completes normally.
